// File: rtl/if_fetch_unit_if.sv
// Instruction-cache request/response bus between the fetch stage and the I-cache.
interface if_fetch_unit_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata;
    logic        imem_busywait;

    // Fetch stage side: issues the read, receives data and busywait.
    modport master (
        output imem_read,
        output imem_address,
        input  imem_readdata,
        input  imem_busywait
    );

    // I-cache side.
    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_readdata,
        output imem_busywait
    );
endinterface

// File: rtl/if_fetch_unit.sv
// PC register and instruction-fetch stage feeding the IF/ID pipeline register.
//
// Handshake: the I-cache word is valid when imem_read=1 and imem_busywait=0.
// Toward IF/ID, an instruction counts as delivered in a cycle where
// busywait_out=0. IF/ID latches it on that rising edge. Every other cycle
// presents BUBBLE, or the held buffer while stalled in HOLD.
//
// FETCH   : reading the cache at pc.
// HOLD    : a hit arrived while stalled. The word is buffered so the cache is
//           not re-read.
// DISCARD : a redirect arrived mid-miss. The miss cannot be aborted, so the
//           returned word is thrown away and the PC jumps afterwards.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_jump_signal,
    input  logic [31:0]            branch_target,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            pc_out,
    output logic [31:0]            pc_4_out,
    output logic [31:0]            instruction_out,
    output logic                   busywait_out,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] buf_q, buf_d;

    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = {branch_target[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            redir_q <= 32'h0000_0000;
            buf_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state, next-PC, redirect and buffer selection. A branch always beats a stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_FETCH: begin
                if (imem.imem_busywait) begin
                    if (branch_jump_signal) begin
                        redir_d = target;
                        state_d = S_DISCARD;
                    end
                end else if (branch_jump_signal) begin
                    pc_d = target;
                end else if (stall) begin
                    buf_d   = imem.imem_readdata;
                    state_d = S_HOLD;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            S_HOLD: begin
                if (branch_jump_signal) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (branch_jump_signal) begin
                    redir_d = target;
                end
                if (!imem.imem_busywait) begin
                    pc_d    = branch_jump_signal ? target : redir_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs. Reset forces an idle bus and a bubble. Only an undisturbed hit or a released HOLD delivers.
    always_comb begin
        imem.imem_read  = 1'b0;
        busywait_out    = 1'b1;
        instruction_out = BUBBLE;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    imem.imem_read = 1'b1;
                    if (!imem.imem_busywait && !branch_jump_signal && !stall) begin
                        busywait_out    = 1'b0;
                        instruction_out = imem.imem_readdata;
                    end
                end
                S_HOLD: begin
                    busywait_out    = stall;
                    instruction_out = buf_q;
                end
                S_DISCARD: begin
                    imem.imem_read = 1'b1;
                end
                default: begin
                    imem.imem_read = 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_address = pc_q;
    assign pc_out            = pc_q;
    assign pc_4_out          = pc_plus4;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. The driver issues one vector per cycle
// and pushes its hand-computed expected outputs. The monitor pops and compares
// at the falling edge.
module tb_if_fetch_unit;

    localparam logic [1:0] ST_F = 2'd0;
    localparam logic [1:0] ST_H = 2'd1;
    localparam logic [1:0] ST_D = 2'd2;
    localparam logic [31:0] D0 = 32'h0050_0093;

    typedef struct packed {
        logic        rd;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
        logic        bwo;
        logic [1:0]  st;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_jump_signal;
    logic [31:0] branch_target;
    logic [31:0] pc_out;
    logic [31:0] pc_4_out;
    logic [31:0] instruction_out;
    logic        busywait_out;
    logic [1:0]  state_dbg;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BUBBLE   (32'h0000_0000)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .branch_jump_signal (branch_jump_signal),
        .branch_target      (branch_target),
        .imem               (bus.master),
        .pc_out             (pc_out),
        .pc_4_out           (pc_4_out),
        .instruction_out    (instruction_out),
        .busywait_out       (busywait_out),
        .state_dbg          (state_dbg)
    );

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply one cycle of inputs and record the expected outputs.
    task automatic step(input logic rst, input logic st, input logic bj,
                        input logic [31:0] tgt, input logic [31:0] rdata,
                        input logic bw, input logic e_rd, input logic [31:0] e_pc,
                        input logic [31:0] e_pc4, input logic [31:0] e_ins,
                        input logic e_bwo, input logic [1:0] e_st);
        exp_t e;
        reset                 = rst;
        stall                 = st;
        branch_jump_signal    = bj;
        branch_target         = tgt;
        bus.imem_readdata     = rdata;
        bus.imem_busywait     = bw;
        e.rd  = e_rd;
        e.pc  = e_pc;
        e.pc4 = e_pc4;
        e.ins = e_ins;
        e.bwo = e_bwo;
        e.st  = e_st;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int vec, input logic [31:0] act,
                       input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL vec%0d %s: got %h expected %h", vec, nm, act, req);
        end
    endtask

    // Monitor: scoreboard pop and compare every cycle a vector is outstanding.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_read",    n_vec, {31'd0, bus.imem_read}, {31'd0, e.rd});
            chk("imem_address", n_vec, bus.imem_address, e.pc);
            chk("pc_out",       n_vec, pc_out, e.pc);
            chk("pc_4_out",     n_vec, pc_4_out, e.pc4);
            chk("instruction",  n_vec, instruction_out, e.ins);
            chk("busywait_out", n_vec, {31'd0, busywait_out}, {31'd0, e.bwo});
            chk("state",        n_vec, {30'd0, state_dbg}, {30'd0, e.st});
            n_vec++;
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_jump_signal = 1'b0;
        branch_target = 32'h0; bus.imem_readdata = 32'h0; bus.imem_busywait = 1'b0;
        @(posedge clk);
        #1;
        //   rst st bj tgt           rdata         bw  rd pc            pc4           ins           bwo st
        // Reset held: idle bus, bubble, PC at RESET_PC
        step(1, 0, 0, 32'h0,        D0,           0,  0, 32'h0,        32'h4,        32'h0,        1, ST_F);
        // 1: streaming hits
        step(0, 0, 0, 32'h0,        D0,           0,  1, 32'h0,        32'h4,        D0,           0, ST_F);
        step(0, 0, 0, 32'h0,        D0,           0,  1, 32'h4,        32'h8,        D0,           0, ST_F);
        step(0, 0, 0, 32'h0,        D0,           0,  1, 32'h8,        32'hC,        D0,           0, ST_F);
        // 2: redirect to 0x10, then a 3-cycle miss
        step(0, 0, 1, 32'h10,       D0,           0,  1, 32'hC,        32'h10,       32'h0,        1, ST_F);
        step(0, 0, 0, 32'h0,        32'hAAAA_AAAA, 1, 1, 32'h10,       32'h14,       32'h0,        1, ST_F);
        step(0, 0, 0, 32'h0,        32'hAAAA_AAAA, 1, 1, 32'h10,       32'h14,       32'h0,        1, ST_F);
        step(0, 0, 0, 32'h0,        32'hAAAA_AAAA, 1, 1, 32'h10,       32'h14,       32'h0,        1, ST_F);
        step(0, 0, 0, 32'h0,        32'h1111_1111, 0, 1, 32'h10,       32'h14,       32'h1111_1111, 0, ST_F);
        // 3: redirect to 0x22 (forced to 0x20), stall for 2 cycles on a hit
        step(0, 0, 1, 32'h22,       D0,           0,  1, 32'h14,       32'h18,       32'h0,        1, ST_F);
        step(0, 1, 0, 32'h0,        32'h2222_2222, 0, 1, 32'h20,       32'h24,       32'h0,        1, ST_F);
        step(0, 1, 0, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'h20,       32'h24,       32'h2222_2222, 1, ST_H);
        step(0, 0, 0, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'h20,       32'h24,       32'h2222_2222, 0, ST_H);
        step(0, 0, 0, 32'h0,        32'h3333_3333, 0, 1, 32'h24,       32'h28,       32'h3333_3333, 0, ST_F);
        // 4: to 0x30, miss, branch 0x103 then 0x200 while the miss is pending
        step(0, 0, 1, 32'h30,       D0,           0,  1, 32'h28,       32'h2C,       32'h0,        1, ST_F);
        step(0, 0, 1, 32'h103,      32'h0,        1,  1, 32'h30,       32'h34,       32'h0,        1, ST_F);
        step(0, 0, 1, 32'h200,      32'h0,        1,  1, 32'h30,       32'h34,       32'h0,        1, ST_D);
        step(0, 1, 0, 32'h0,        32'h0,        1,  1, 32'h30,       32'h34,       32'h0,        1, ST_D);
        step(0, 0, 0, 32'h0,        32'h4444_4444, 0, 1, 32'h30,       32'h34,       32'h0,        1, ST_D);
        step(0, 0, 0, 32'h0,        32'h5555_5555, 0, 1, 32'h200,      32'h204,      32'h5555_5555, 0, ST_F);
        // 5: branch and stall on the same hit cycle, so HOLD is never entered
        step(0, 1, 1, 32'h40,       32'hBBBB_BBBB, 0, 1, 32'h204,      32'h208,      32'h0,        1, ST_F);
        step(0, 0, 0, 32'h0,        32'h6666_6666, 0, 1, 32'h40,       32'h44,       32'h6666_6666, 0, ST_F);
        // 6: wrap at the top of memory, then reset mid-miss with a pending redirect
        step(0, 0, 1, 32'hFFFF_FFFF, D0,          0,  1, 32'h44,       32'h48,       32'h0,        1, ST_F);
        step(0, 0, 0, 32'h0,        32'h7777_7777, 0, 1, 32'hFFFF_FFFC, 32'h0,       32'h7777_7777, 0, ST_F);
        step(0, 0, 0, 32'h0,        32'h0,        1,  1, 32'h0,        32'h4,        32'h0,        1, ST_F);
        step(0, 0, 1, 32'h80,       32'h0,        1,  1, 32'h0,        32'h4,        32'h0,        1, ST_F);
        step(1, 0, 0, 32'h0,        32'h0,        1,  0, 32'h0,        32'h4,        32'h0,        1, ST_D);
        step(0, 0, 0, 32'h0,        32'h8888_8888, 0, 1, 32'h0,        32'h4,        32'h8888_8888, 0, ST_F);
        step(0, 0, 0, 32'h0,        32'h9999_9999, 0, 1, 32'h4,        32'h8,        32'h9999_9999, 0, ST_F);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d vectors left expected 0", exp_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Holds the PC and drives read requests to the instruction cache.
- Absorbs cache busywait, hazard stalls and branch/jump redirects.
- Presents pc, pc+4, instruction and busywait to IF/ID, which latches them when busywait is low and flushes to zero on branch_jump_signal.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUBBLE, 32'h0000_0000, instruction value driven whenever no valid instruction is delivered (matches IF/ID flush value).

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hazard-unit hold; PC must not advance.
branch_jump_signal  in  1  redirect request from EX; same signal that flushes IF/ID.
branch_target  in  32  redirect address; bits [1:0] ignored and forced to 00.
imem_readdata  in  32  instruction from I-cache; valid when imem_read=1 and imem_busywait=0.
imem_busywait  in  1  I-cache busy (miss in progress).
imem_read  out  1  I-cache read request.
imem_address  out  32  I-cache address; always equals the PC register.
pc_out  out  32  PC of the delivered instruction, to IF/ID pc_in.
pc_4_out  out  32  pc_out+4 modulo 2^32, to IF/ID pc_4_in.
instruction_out  out  32  delivered instruction, to IF/ID instration_in.
busywait_out  out  1  high = IF/ID must hold; to IF/ID busywait.

Behaviour:
- Clock/reset: single clock clk; reset is synchronous, active-high. While reset is high: imem_read=0, busywait_out=1, instruction_out=BUBBLE. On the reset edge: pc<=RESET_PC, state<=FETCH, pending redirect and buffer cleared. After reset: pc_out=RESET_PC, pc_4_out=RESET_PC+4.
- pc_out, pc_4_out and imem_address come from the registered PC. instruction_out and busywait_out are combinational from state, the buffer and the cache signals.
- FETCH state: imem_read=1.
  - imem_busywait=1: busywait_out=1, instruction_out=BUBBLE, PC held. If branch_jump_signal=1, latch redir_pc<=branch_target and go to DISCARD; the in-flight miss cannot be aborted.
  - imem_busywait=0, branch_jump_signal=1: pc<=branch_target, stay in FETCH; fetched word dropped; branch has priority over stall.
  - imem_busywait=0, stall=1: buf<=imem_readdata, go to HOLD, busywait_out=1.
  - imem_busywait=0, stall=0: instruction_out=imem_readdata, busywait_out=0, pc<=pc+4.
- HOLD state: imem_read=0, instruction_out=buf, busywait_out=stall.
  - branch_jump_signal=1: pc<=branch_target, buf dropped, go to FETCH.
  - stall=0: instruction delivered this cycle, pc<=pc+4, go to FETCH. The cache is never re-read for a buffered word.
- DISCARD state: imem_read=1 on the old address, busywait_out=1, instruction_out=BUBBLE.
  - A further branch_jump_signal overwrites redir_pc; latest wins.
  - When imem_busywait=0: returned word dropped, pc<=redir_pc, go to FETCH.
  - stall is ignored in DISCARD.
- Arithmetic: pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. branch_target[1:0] forced to 00 everywhere.
- Reset mid-miss: imem_read drops during the reset cycle; the I-cache drops a request when imem_read is deasserted. Any pending redirect is discarded.
- Simultaneous stall and branch: branch wins in all states.
- Exactly one delivery (busywait_out=0 with a non-bubble instruction) occurs per PC value unless it is redirected away.

Test Plan:
1. Reset with RESET_PC=0, cache always hit (busywait=0), readdata=0x00500093 -> pc_out sequence 0,4,8 on consecutive cycles, busywait_out=0, imem_address tracks pc_out.
2. Miss: imem_busywait high for 3 cycles at pc=0x10 -> busywait_out=1 and instruction_out=0 for 3 cycles; on the 4th cycle the word is delivered, then pc=0x14.
3. Stall on hit at pc=0x20, stall high for 2 cycles -> one imem_read in cycle 0 then imem_read=0. instruction_out holds buffered word with busywait_out=1. On release it is delivered once and pc becomes 0x24.
4. Branch to 0x103 during a miss at pc=0x30, then a second branch to 0x200 before the miss ends -> returned word discarded, busywait_out=1 throughout, next imem_address=0x200.
5. Branch to 0x40 on the same cycle as a hit with stall=1 -> pc=0x40 next cycle, state FETCH, no HOLD entered.
6. pc=0xFFFF_FFFC hit, then assert reset for one cycle during a subsequent miss -> pc wraps to 0, then returns to RESET_PC; imem_read=0 during reset; outputs at reset values.
